// File: rtl/systolic_weight_loader.sv
// Streams ROWS weight rows into the top of the PE weight-pass chain, then fires one capture strobe.
// Optional WEIGHT_LOADER_STALL_CNT_EN adds stall_cnt (SHIFT cycles without valid, CAPTURE cycles blocked).
module systolic_weight_loader #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       compute_idle,
  input  logic                       wt_valid,
  output logic                       wt_ready,
  input  logic [COLS*DATA_WIDTH-1:0] wt_data,
  output logic [COLS*DATA_WIDTH-1:0] weight_out,
  output logic                       en_weight_pass,
  output logic                       en_weight_capture,
  output logic                       busy,
  output logic                       done
`ifdef WEIGHT_LOADER_STALL_CNT_EN
  ,
  output logic [31:0]                stall_cnt
`endif
);

  localparam int CW = $clog2(ROWS + 1);
  localparam int W  = COLS * DATA_WIDTH;
  localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    wout_q, wout_d;
  logic            pass_q, pass_d;

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    wout_d            = wout_q;
    pass_d            = 1'b0;
    wt_ready          = 1'b0;
    en_weight_capture = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end
      end
      S_SHIFT: begin
        wt_ready = 1'b1;
        if (wt_valid) begin
          pass_d = 1'b1;
          wout_d = wt_data;
          cnt_d  = cnt_q + CW'(1);
          if (cnt_q == LAST_ROW) state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // The final pass pulse coincides with this cycle, so PEs latch post-shift data.
        if (compute_idle) begin
          en_weight_capture = 1'b1;
          state_d           = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst) wout_q[gi*DATA_WIDTH +: DATA_WIDTH] <= '0;
      else     wout_q[gi*DATA_WIDTH +: DATA_WIDTH] <= wout_d[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign weight_out     = wout_q;
  assign en_weight_pass = pass_q;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);

`ifdef WEIGHT_LOADER_STALL_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      stall_q <= '0;
    end else if (((state_q == S_SHIFT && !wt_valid) ||
                  (state_q == S_CAPTURE && !compute_idle)) && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_systolic_weight_loader.sv
// Randomized bench for systolic_weight_loader: two instances (ROWS=4 and ROWS=1) share stimulus
// and are checked every cycle against a transaction-level model plus a PE weight-chain model.
module tb_systolic_weight_loader;
  localparam int COLS = 4;
  localparam int DW   = 8;
  localparam int W    = COLS * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ci = 1'b1;
  logic valid = 1'b0;
  logic [W-1:0] data = '0;

  logic [1:0] rdy, pass, cap, busy, done;
  logic [1:0][W-1:0] wout;
`ifdef WEIGHT_LOADER_STALL_CNT_EN
  logic [1:0][31:0] stall;
`endif

  always #5 clk = ~clk;

  systolic_weight_loader #(.ROWS(4), .COLS(COLS), .DATA_WIDTH(DW)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .compute_idle(ci), .wt_valid(valid),
    .wt_ready(rdy[0]), .wt_data(data), .weight_out(wout[0]), .en_weight_pass(pass[0]),
    .en_weight_capture(cap[0]), .busy(busy[0]), .done(done[0])
`ifdef WEIGHT_LOADER_STALL_CNT_EN
    , .stall_cnt(stall[0])
`endif
  );

  systolic_weight_loader #(.ROWS(1), .COLS(COLS), .DATA_WIDTH(DW)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .compute_idle(ci), .wt_valid(valid),
    .wt_ready(rdy[1]), .wt_data(data), .weight_out(wout[1]), .en_weight_pass(pass[1]),
    .en_weight_capture(cap[1]), .busy(busy[1]), .done(done[1])
`ifdef WEIGHT_LOADER_STALL_CNT_EN
    , .stall_cnt(stall[1])
`endif
  );

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  task automatic chk(input int k, input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL dut%0d %s: got %h expected %h at %0t", k, nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0 idle, 1 loading, 2 awaiting capture, 3 done pulse.
  int           rr [2] = '{4, 1};
  int           m_phase [2];
  int           m_nb [2];
  logic         m_pass [2];
  logic [W-1:0] m_wout [2];
  logic [31:0]  m_stall [2];
  logic [W-1:0] m_beats [2][4];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_nb[k] = 0; m_pass[k] = 1'b0; m_wout[k] = '0; m_stall[k] = '0;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int ph = m_phase[k];
      automatic bit x  = (ph == 1) && valid;
      if (rst) begin
        m_phase[k] = 0; m_nb[k] = 0; m_pass[k] = 1'b0; m_wout[k] = '0; m_stall[k] = '0;
      end else begin
        if (((ph == 1) && !valid) || ((ph == 2) && !ci)) begin
          if (m_stall[k] != 32'hFFFF_FFFF) m_stall[k] = m_stall[k] + 1;
        end
        if (ph == 0 && start) m_stall[k] = '0;
        m_pass[k] = x;
        if (x) begin
          m_wout[k] = data;
          m_beats[k][m_nb[k]] = data;
          m_nb[k]++;
        end
        case (ph)
          0: if (start) begin m_phase[k] = 1; m_nb[k] = 0; end
          1: if (x && m_nb[k] == rr[k]) m_phase[k] = 2;
          2: if (ci) m_phase[k] = 3;
          default: m_phase[k] = 0;
        endcase
      end
    end
  end

  // PE weight chain driven by the DUT outputs; row 0 is the top row.
  logic [W-1:0] pe [2][4];
  logic [W-1:0] lastcap [2][4];
  int ncap [2] = '{0, 0};
  int ndone [2] = '{0, 0};

  always @(negedge clk) begin
    if (checking) begin
      for (int k = 0; k < 2; k++) begin
        chk(k, "wt_ready", W'(rdy[k]), W'(m_phase[k] == 1));
        chk(k, "en_weight_pass", W'(pass[k]), W'(m_pass[k]));
        chk(k, "weight_out", wout[k], m_wout[k]);
        chk(k, "en_weight_capture", W'(cap[k]), W'((m_phase[k] == 2) && ci));
        chk(k, "busy", W'(busy[k]), W'(m_phase[k] != 0));
        chk(k, "done", W'(done[k]), W'(m_phase[k] == 3));
`ifdef WEIGHT_LOADER_STALL_CNT_EN
        chk(k, "stall_cnt", stall[k], m_stall[k]);
`endif
        if (pass[k]) begin
          for (int r = rr[k] - 1; r > 0; r--) pe[k][r] = pe[k][r-1];
          pe[k][0] = wout[k];
        end
        if (cap[k]) begin
          ncap[k]++;
          for (int r = 0; r < rr[k]; r++) begin
            chk(k, "pe_row_captured", pe[k][r], m_beats[k][rr[k]-1-r]);
            lastcap[k][r] = pe[k][r];
          end
        end
        if (done[k]) ndone[k]++;
      end
    end
  end

  task automatic run_tile(input logic [W-1:0] rows [4], input int gap_at, input int gap_len,
                          input int ci_low, input bit restart_pulse, output int done_cyc);
    int  idx = 0;
    int  gl = gap_len;
    int  cl = ci_low;
    int  nd0 = ndone[0];
    int  nc0 = ncap[0];
    bit  acc = 1'b0;
    bit  seen = 1'b0;
    done_cyc = -1;
    for (int cyc = 0; cyc < 200 && !seen; cyc++) begin
      @(posedge clk); #1;
      if (acc) idx++;
      start = (cyc == 0) || (restart_pulse && idx == 1);
      valid = (idx < 4);
      if (idx == gap_at && gl > 0) begin
        valid = 1'b0;
        gl--;
      end
      data = (idx < 4) ? rows[idx] : W'($urandom);
      if (cl > 0) begin
        ci = 1'b0;
        if (busy[0] && !rdy[0] && !done[0]) cl--;
      end else begin
        ci = 1'b1;
      end
      acc = valid && rdy[0];
      if (done[0]) begin
        seen = 1'b1;
        done_cyc = cyc;
      end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL dut0 tile_timeout: got no done expected done within 200 cycles");
    end
    @(posedge clk); #1;
    start = 1'b0; valid = 1'b0; ci = 1'b1;
    @(posedge clk); #1;
    chk(0, "dones_per_tile", W'(ndone[0] - nd0), W'(1));
    chk(0, "captures_per_tile", W'(ncap[0] - nc0), W'(1));
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got no finish expected finish before 300us");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] rows [4];
    int dc;
    int nc_before;
    rows[0] = 32'h0403_0201; rows[1] = 32'h1413_1211;
    rows[2] = 32'h2423_2221; rows[3] = 32'h3433_3231;

    @(posedge clk); #1;
    checking = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    chk(0, "reset_busy", W'(busy[0]), W'(0));
    chk(0, "reset_weight_out", wout[0], W'(0));

    // Continuous tile; start at cycle 0 means done in cycle ROWS+2.
    run_tile(rows, 9, 0, 0, 1'b0, dc);
    chk(0, "start_to_done_latency", W'(dc), W'(6));
    chk(0, "top_row_literal", lastcap[0][0], 32'h3433_3231);
    chk(0, "bottom_row_literal", lastcap[0][3], 32'h0403_0201);
    chk(1, "rows1_literal", lastcap[1][0], 32'h0403_0201);

    run_tile(rows, 2, 2, 0, 1'b0, dc);
    chk(0, "gap_latency", W'(dc), W'(8));
`ifdef WEIGHT_LOADER_STALL_CNT_EN
    chk(0, "stall_gap_literal", stall[0], 32'd2);
`endif

    run_tile(rows, 9, 0, 5, 1'b0, dc);
    chk(0, "ci_low_latency", W'(dc), W'(11));
`ifdef WEIGHT_LOADER_STALL_CNT_EN
    chk(0, "stall_ci_literal", stall[0], 32'd5);
`endif

    run_tile(rows, 9, 0, 0, 1'b1, dc);
    chk(0, "restart_ignored_latency", W'(dc), W'(6));

    // Abort after two beats with reset.
    nc_before = ncap[0];
    start = 1'b1; valid = 1'b0;
    @(posedge clk); #1; start = 1'b0; valid = 1'b1; data = 32'hDEAD_0001;
    @(posedge clk); #1; data = 32'hDEAD_0002;
    @(posedge clk); #1; valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk(0, "abort_busy", W'(busy[0]), W'(0));
    chk(0, "abort_ready", W'(rdy[0]), W'(0));
    chk(0, "abort_pass", W'(pass[0]), W'(0));
    chk(0, "abort_weight_out", wout[0], W'(0));
    repeat (3) @(posedge clk); #1;
    chk(0, "abort_no_capture", W'(ncap[0] - nc_before), W'(0));
    run_tile(rows, 9, 0, 0, 1'b0, dc);
    chk(0, "post_abort_top_row", lastcap[0][0], 32'h3433_3231);

    for (int t = 0; t < 20; t++) begin
      for (int r = 0; r < 4; r++) rows[r] = W'($urandom);
      run_tile(rows, $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), dc);
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
